// File: rtl/range_job_sched.sv
// Range job scheduler: splits [lo,hi] ranges into digit-uniform jobs,
// feeds the sum engine one job at a time and accumulates the results.
//
// Ports:
//   clock, reset (sync, active-low)
//   rng_valid/rng_ready/rng_lo/rng_hi/rng_last  : range input handshake
//   job_valid/job_ready/job_lo/job_hi/job_n_digs : job to sum engine
//   res_valid/res_sum                            : engine result pulse
//   total_valid/total                            : grand total pulse
//   busy, err_range                              : status
module range_job_sched #(
    parameter int DATA_W   = 64,
    parameter int ACC_W    = 128,
    parameter int MAX_DIGS = 10
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            rng_valid,
    output logic                            rng_ready,
    input  logic [DATA_W-1:0]               rng_lo,
    input  logic [DATA_W-1:0]               rng_hi,
    input  logic                            rng_last,
    output logic                            job_valid,
    input  logic                            job_ready,
    output logic [DATA_W-1:0]               job_lo,
    output logic [DATA_W-1:0]               job_hi,
    output logic [$clog2(MAX_DIGS+1)-1:0]   job_n_digs,
    input  logic                            res_valid,
    input  logic [ACC_W-1:0]                res_sum,
    output logic                            total_valid,
    output logic [ACC_W-1:0]                total,
    output logic                            busy,
    output logic                            err_range
);

    localparam int DIG_W = $clog2(MAX_DIGS+1);
    localparam int TBL_N = 1 << DIG_W;

    typedef logic [DATA_W-1:0] word_t;

    function automatic word_t pow10(input int n);
        word_t p;
        p = word_t'(1);
        for (int i = 0; i < n; i++) p = (p << 3) + (p << 1);
        return p;
    endfunction

    localparam word_t P_MAX = pow10(MAX_DIGS);

    typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, DONE} state_t;

    state_t           state, state_next;
    word_t            p10 [TBL_N];
    word_t            cur_lo, hi_q, lo_c;
    logic             last_q;
    logic [DIG_W-1:0] d, d_inc;
    logic [ACC_W-1:0] acc, acc_sum;
    logic             too_wide, empty, fin;

    // Constant power-of-ten table; slots past MAX_DIGS saturate.
    for (genvar g = 0; g < TBL_N; g++) begin : g_p10
        assign p10[g] = (g <= MAX_DIGS) ? pow10(g) : '1;
    end

    assign d_inc    = d + DIG_W'(1);
    assign lo_c     = (rng_lo == '0) ? word_t'(1) : rng_lo;
    assign too_wide = rng_hi >= P_MAX;
    assign empty    = lo_c > rng_hi;
    assign fin      = job_hi == hi_q;
    assign acc_sum  = acc + res_sum;

    always_ff @(posedge clock) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next  = state;
        rng_ready   = 1'b0;
        job_valid   = 1'b0;
        total_valid = 1'b0;
        busy        = 1'b1;
        unique case (state)
            IDLE: begin
                rng_ready = 1'b1;
                busy      = 1'b0;
                if (rng_valid) begin
                    if (empty || too_wide)
                        state_next = rng_last ? DONE : IDLE;
                    else
                        state_next = SCAN;
                end
            end
            SCAN: begin
                if (cur_lo < p10[d]) state_next = ISSUE;
            end
            ISSUE: begin
                job_valid = 1'b1;
                if (job_ready) state_next = WAIT;
            end
            WAIT: begin
                if (res_valid) begin
                    if (fin) state_next = last_q ? DONE : IDLE;
                    else     state_next = ISSUE;
                end
            end
            DONE: begin
                total_valid = 1'b1;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cur_lo     <= '0;
            hi_q       <= '0;
            last_q     <= 1'b0;
            d          <= '0;
            acc        <= '0;
            total      <= '0;
            job_lo     <= '0;
            job_hi     <= '0;
            job_n_digs <= '0;
            err_range  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rng_valid) begin
                        cur_lo <= lo_c;
                        hi_q   <= rng_hi;
                        last_q <= rng_last;
                        d      <= DIG_W'(1);
                        if (too_wide) err_range <= 1'b1;
                    end
                end
                SCAN: begin
                    if (cur_lo >= p10[d]) begin
                        d <= d_inc;
                    end else begin
                        job_lo     <= cur_lo;
                        job_hi     <= (hi_q < p10[d]) ? hi_q
                                      : p10[d] - word_t'(1);
                        job_n_digs <= d;
                    end
                end
                WAIT: begin
                    if (res_valid) begin
                        acc <= acc_sum;
                        // Next job starts at the next power of ten;
                        // no rescan is needed.
                        if (!fin) begin
                            cur_lo     <= p10[d];
                            d          <= d_inc;
                            job_lo     <= p10[d];
                            job_hi     <= (hi_q < p10[d_inc]) ? hi_q
                                          : p10[d_inc] - word_t'(1);
                            job_n_digs <= d_inc;
                        end
                    end
                end
                DONE: acc <= '0;
                default: ;
            endcase
            // total must already show the sum during the DONE cycle.
            if (state_next == DONE && state != DONE)
                total <= (state == WAIT) ? acc_sum : acc;
        end
    end

endmodule

// File: tb/tb_range_job_sched.sv
// Directed testbench for range_job_sched.
// Plays the sum engine by hand and checks jobs and totals.
module tb_range_job_sched;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rng_valid = 1'b0;
    logic          rng_ready;
    logic [63:0]   rng_lo = '0;
    logic [63:0]   rng_hi = '0;
    logic          rng_last = 1'b0;
    logic          job_valid;
    logic          job_ready = 1'b0;
    logic [63:0]   job_lo;
    logic [63:0]   job_hi;
    logic [3:0]    job_n_digs;
    logic          res_valid = 1'b0;
    logic [127:0]  res_sum = '0;
    logic          total_valid;
    logic [127:0]  total;
    logic          busy;
    logic          err_range;

    int nvec = 0;
    int nerr = 0;

    range_job_sched #(.DATA_W(64), .ACC_W(128), .MAX_DIGS(10)) dut (
        .clock(clock), .reset(reset),
        .rng_valid(rng_valid), .rng_ready(rng_ready),
        .rng_lo(rng_lo), .rng_hi(rng_hi), .rng_last(rng_last),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_lo(job_lo), .job_hi(job_hi), .job_n_digs(job_n_digs),
        .res_valid(res_valid), .res_sum(res_sum),
        .total_valid(total_valid), .total(total),
        .busy(busy), .err_range(err_range)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic offer(input logic [63:0] lo, input logic [63:0] hi,
                         input logic last);
        rng_valid = 1'b1;
        rng_lo    = lo;
        rng_hi    = hi;
        rng_last  = last;
        tick();
        rng_valid = 1'b0;
        rng_last  = 1'b0;
    endtask

    task automatic wait_job(output bit seen, output int cyc);
        seen = 1'b0;
        cyc  = 0;
        for (int i = 0; i < 30; i++) begin
            if (job_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
    endtask

    task automatic wait_total(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (total_valid) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic take_job();
        job_ready = 1'b1;
        tick();
        job_ready = 1'b0;
    endtask

    task automatic send_res(input logic [127:0] s);
        res_valid = 1'b1;
        res_sum   = s;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        nvec++;
        if ({rng_ready, job_valid, total_valid, busy, err_range} !== 5'b10000) begin
            nerr++;
            $display("FAIL reset_flags got %b want 10000",
                     {rng_ready, job_valid, total_valid, busy, err_range});
        end
        nvec++;
        if ({total, job_lo, job_hi, job_n_digs} !== '0) begin
            nerr++;
            $display("FAIL reset_data got %h/%h/%h/%h want 0",
                     total, job_lo, job_hi, job_n_digs);
        end
    endtask

    task automatic test_single();
        bit seen;
        int cyc;
        offer(64'd11, 64'd22, 1'b1);
        wait_job(seen, cyc);
        nvec++;
        if (!seen || cyc != 2) begin
            nerr++;
            $display("FAIL t1_scan got seen=%0d cyc=%0d want seen=1 cyc=2",
                     seen, cyc);
        end
        nvec++;
        if ({job_lo, job_hi, job_n_digs} !== {64'd11, 64'd22, 4'd2}) begin
            nerr++;
            $display("FAIL t1_job got %0d,%0d,%0d want 11,22,2",
                     job_lo, job_hi, job_n_digs);
        end
        take_job();
        nvec++;
        if (job_valid !== 1'b0) begin
            nerr++;
            $display("FAIL t1_wait_jv got %b want 0", job_valid);
        end
        send_res(128'd33);
        wait_total(seen);
        nvec++;
        if (!seen || total !== 128'd33) begin
            nerr++;
            $display("FAIL t1_total got seen=%0d total=%0d want 1,33",
                     seen, total);
        end
        tick();
        nvec++;
        if ({total_valid, rng_ready} !== 2'b01 || total !== 128'd33) begin
            nerr++;
            $display("FAIL t1_after got tv=%b rr=%b total=%0d want 0,1,33",
                     total_valid, rng_ready, total);
        end
    endtask

    task automatic test_split();
        bit seen;
        int cyc;
        offer(64'd95, 64'd115, 1'b1);
        wait_job(seen, cyc);
        nvec++;
        if (!seen || {job_lo, job_hi, job_n_digs} !== {64'd95, 64'd99, 4'd2}) begin
            nerr++;
            $display("FAIL t2_job0 got seen=%0d %0d,%0d,%0d want 95,99,2",
                     seen, job_lo, job_hi, job_n_digs);
        end
        take_job();
        send_res(128'd99);
        nvec++;
        if (job_valid !== 1'b1 ||
            {job_lo, job_hi, job_n_digs} !== {64'd100, 64'd115, 4'd3}) begin
            nerr++;
            $display("FAIL t2_job1 got jv=%b %0d,%0d,%0d want 1 100,115,3",
                     job_valid, job_lo, job_hi, job_n_digs);
        end
        take_job();
        send_res(128'd111);
        wait_total(seen);
        nvec++;
        if (!seen || total !== 128'd210) begin
            nerr++;
            $display("FAIL t2_total got seen=%0d total=%0d want 1,210",
                     seen, total);
        end
        tick();
    endtask

    task automatic test_stall();
        bit seen;
        int cyc;
        offer(64'd300, 64'd350, 1'b1);
        wait_job(seen, cyc);
        for (int i = 0; i < 5; i++) begin
            nvec++;
            if ({job_valid, rng_ready, busy} !== 3'b101 ||
                {job_lo, job_hi, job_n_digs} !== {64'd300, 64'd350, 4'd3}) begin
                nerr++;
                $display("FAIL t3_stall%0d got %b %0d,%0d,%0d want 101 300,350,3",
                         i, {job_valid, rng_ready, busy},
                         job_lo, job_hi, job_n_digs);
            end
            tick();
        end
        // result offered in the handshake cycle must be ignored
        job_ready = 1'b1;
        res_valid = 1'b1;
        res_sum   = 128'd1000;
        tick();
        job_ready = 1'b0;
        res_valid = 1'b0;
        nvec++;
        if ({job_valid, total_valid, busy} !== 3'b001) begin
            nerr++;
            $display("FAIL t3_wait got %b want 001",
                     {job_valid, total_valid, busy});
        end
        send_res(128'd7);
        wait_total(seen);
        nvec++;
        if (!seen || total !== 128'd7) begin
            nerr++;
            $display("FAIL t3_total got seen=%0d total=%0d want 1,7",
                     seen, total);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit seen;
        int cyc;
        offer(64'd0, 64'd9, 1'b0);
        wait_job(seen, cyc);
        nvec++;
        if (!seen || {job_lo, job_hi, job_n_digs} !== {64'd1, 64'd9, 4'd1}) begin
            nerr++;
            $display("FAIL t4_job0 got seen=%0d %0d,%0d,%0d want 1,9,1",
                     seen, job_lo, job_hi, job_n_digs);
        end
        take_job();
        send_res(128'd45);
        nvec++;
        if ({total_valid, rng_ready, busy} !== 3'b010) begin
            nerr++;
            $display("FAIL t4_mid got %b want 010",
                     {total_valid, rng_ready, busy});
        end
        offer(64'd998, 64'd1012, 1'b1);
        wait_job(seen, cyc);
        nvec++;
        if (!seen || cyc != 3 ||
            {job_lo, job_hi, job_n_digs} !== {64'd998, 64'd999, 4'd3}) begin
            nerr++;
            $display("FAIL t4_job1 got cyc=%0d %0d,%0d,%0d want 3 998,999,3",
                     cyc, job_lo, job_hi, job_n_digs);
        end
        take_job();
        send_res(128'd1997);
        nvec++;
        if (job_valid !== 1'b1 ||
            {job_lo, job_hi, job_n_digs} !== {64'd1000, 64'd1012, 4'd4}) begin
            nerr++;
            $display("FAIL t4_job2 got jv=%b %0d,%0d,%0d want 1 1000,1012,4",
                     job_valid, job_lo, job_hi, job_n_digs);
        end
        take_job();
        send_res(128'd13078);
        wait_total(seen);
        nvec++;
        if (!seen || total !== 128'd15120) begin
            nerr++;
            $display("FAIL t4_total got seen=%0d total=%0d want 1,15120",
                     seen, total);
        end
        tick();
        nvec++;
        if (total_valid !== 1'b0) begin
            nerr++;
            $display("FAIL t4_pulse got %b want 0", total_valid);
        end
    endtask

    task automatic test_reject();
        bit seen;
        int cyc;
        offer(64'd50, 64'd40, 1'b1);
        nvec++;
        if ({total_valid, job_valid} !== 2'b10 || total !== 128'd0) begin
            nerr++;
            $display("FAIL t5_empty got tv=%b jv=%b total=%0d want 1,0,0",
                     total_valid, job_valid, total);
        end
        tick();
        offer(64'd5, 64'd10000000000, 1'b0);
        nvec++;
        if ({err_range, job_valid, rng_ready, busy} !== 4'b1010) begin
            nerr++;
            $display("FAIL t5_wide got %b want 1010",
                     {err_range, job_valid, rng_ready, busy});
        end
        tick();
        tick();
        nvec++;
        if ({err_range, job_valid, total_valid} !== 3'b100) begin
            nerr++;
            $display("FAIL t5_sticky got %b want 100",
                     {err_range, job_valid, total_valid});
        end
        offer(64'd9999999990, 64'd9999999999, 1'b1);
        wait_job(seen, cyc);
        nvec++;
        if (!seen || cyc != 10 ||
            {job_lo, job_hi, job_n_digs} !==
            {64'd9999999990, 64'd9999999999, 4'd10}) begin
            nerr++;
            $display("FAIL t5_maxdig got cyc=%0d %0d,%0d,%0d want 10 9999999990,9999999999,10",
                     cyc, job_lo, job_hi, job_n_digs);
        end
        take_job();
        send_res(128'd1);
        wait_total(seen);
        nvec++;
        if (!seen || total !== 128'd1) begin
            nerr++;
            $display("FAIL t5_total got seen=%0d total=%0d want 1,1",
                     seen, total);
        end
        tick();
    endtask

    task automatic test_reset_in_wait();
        bit seen;
        int cyc;
        offer(64'd11, 64'd22, 1'b0);
        wait_job(seen, cyc);
        take_job();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        nvec++;
        if ({job_valid, rng_ready, busy, total_valid, err_range} !== 5'b01000) begin
            nerr++;
            $display("FAIL t6_reset got %b want 01000",
                     {job_valid, rng_ready, busy, total_valid, err_range});
        end
        send_res(128'd100);
        nvec++;
        if ({total_valid, busy, job_valid} !== 3'b000) begin
            nerr++;
            $display("FAIL t6_late_res got %b want 000",
                     {total_valid, busy, job_valid});
        end
        offer(64'd50, 64'd40, 1'b1);
        nvec++;
        if (total_valid !== 1'b1 || total !== 128'd0) begin
            nerr++;
            $display("FAIL t6_acc got tv=%b total=%0d want 1,0",
                     total_valid, total);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_split();
        test_stall();
        test_back_to_back();
        test_reject();
        test_reset_in_wait();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
